// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - memory-control codes shared with the cores and arbiter FSM encoding
package mem_pkg;

  localparam logic [3:0] MEMC_READ  = 4'h1;
  localparam logic [3:0] MEMC_WRITE = 4'h2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  function automatic logic is_mem_req(input logic [3:0] ctrl);
    return (ctrl == MEMC_READ) || (ctrl == MEMC_WRITE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_valid
);

  always_comb begin : p_scan
    logic [PW:0] pos;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    pos       = '0;
    // Scan from farthest to nearest so the requester closest to ptr is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (PW + 1)'(k);
      if (pos >= (PW + 1)'(N)) begin
        pos = pos - (PW + 1)'(N);
      end
      if (req[pos[PW-1:0]]) begin
        gnt_idx   = pos[PW-1:0];
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one synchronous data RAM among NCORES cores
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int NCORES  = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RAM_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [4*NCORES-1:0]  mem_ctrl,
  input  logic [AW*NCORES-1:0] daddr,
  input  logic [DW*NCORES-1:0] ddout,
  output logic [NCORES-1:0]    acq,
  output logic [DW-1:0]        ddin,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_wdata,
  output logic                 ram_we,
  output logic                 ram_re,
  input  logic [DW-1:0]        ram_rdata,
  output logic                 busy
);

  localparam int PW = $clog2(NCORES);

  arb_state_t        state, state_n;
  logic [NCORES-1:0] req;
  logic [PW-1:0]     ptr, grant, gnt_idx;
  logic              gnt_valid, op_wr;
  logic              take, capture, ack_set;
  logic [1:0]        wait_cnt;
  logic [3:0]        gnt_ctrl;

  always_comb begin
    req = '0;
    for (int i = 0; i < NCORES; i++) begin
      req[i] = is_mem_req(mem_ctrl[4*i +: 4]);
    end
  end

  rr_arbiter #(.N(NCORES), .PW(PW)) u_rr (
    .req       (req),
    .ptr       (ptr),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign gnt_ctrl = mem_ctrl[4*gnt_idx +: 4];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    capture = 1'b0;
    ack_set = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          take    = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        ack_set = op_wr;
        state_n = op_wr ? ACK : WAIT;
      end
      WAIT: begin
        if (wait_cnt == 2'(RAM_LAT - 1)) begin
          capture = 1'b1;
          ack_set = 1'b1;
          state_n = ACK;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ram_addr/ram_wdata double as the address/data latches for the whole access.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ptr       <= '0;
      grant     <= '0;
      op_wr     <= 1'b0;
      wait_cnt  <= 2'd0;
      acq       <= '0;
      ddin      <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
    end else begin
      ram_we   <= take && (gnt_ctrl == MEMC_WRITE);
      ram_re   <= take && (gnt_ctrl == MEMC_READ);
      acq      <= ack_set ? (NCORES'(1) << grant) : '0;
      wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
      if (take) begin
        grant     <= gnt_idx;
        op_wr     <= (gnt_ctrl == MEMC_WRITE);
        ram_addr  <= daddr[AW*gnt_idx +: AW];
        ram_wdata <= ddout[DW*gnt_idx +: DW];
      end
      if (capture) ddin <= ram_rdata;
      if (state == ACK) ptr <= (grant == PW'(NCORES - 1)) ? '0 : grant + 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule
